// File: rtl/simmem_delay_releaser.sv
// simmem_delay_releaser
//
// Holds delayed requests in a pool of slots and counts each one down by its
// simulated latency. When a slot expires it grants one release credit to its
// AXI ID. A per-ID release enable stays high while that ID holds credits, and
// every completed bank handshake for the ID consumes one credit.
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   req_valid_i    new delayed request presented
//   req_ready_o    a free slot exists (registered state only)
//   req_id_i       AXI ID of the request
//   req_delay_i    latency in cycles before release
//   rel_done_i     bank completed one output handshake
//   rel_done_id_i  ID of that handshake
//   release_en_o   per-ID release enable (one bit per ID)

module simmem_delay_releaser #(
    parameter int IDWidth    = 8,
    parameter int NumSlots   = 32,
    parameter int DelayWidth = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [IDWidth-1:0]      req_id_i,
    input  logic [DelayWidth-1:0]   req_delay_i,
    input  logic                    rel_done_i,
    input  logic [IDWidth-1:0]      rel_done_id_i,
    output logic [2**IDWidth-1:0]   release_en_o
);

    localparam int NumIds      = 2**IDWidth;
    localparam int CreditWidth = $clog2(NumSlots + 1);

    logic [NumSlots-1:0]    slot_valid_q, slot_valid_d;
    logic [IDWidth-1:0]     slot_id_q  [NumSlots];
    logic [IDWidth-1:0]     slot_id_d  [NumSlots];
    logic [DelayWidth-1:0]  slot_cnt_q [NumSlots];
    logic [DelayWidth-1:0]  slot_cnt_d [NumSlots];
    logic [CreditWidth-1:0] credit_q   [NumIds];
    logic [CreditWidth-1:0] credit_d   [NumIds];
    logic [NumIds-1:0]      release_en_q, release_en_d;

    logic [NumSlots-1:0]    slot_expired;
    logic [NumSlots-1:0]    alloc_oh;
    logic                   accept;
    logic                   credit_overflow;
    logic                   credit_underflow;

    // Ready depends only on the registered valid bits, so a slot that expires
    // this cycle is not offered until the cycle after it has cleared.
    assign req_ready_o  = |(~slot_valid_q);
    assign accept       = req_valid_i && req_ready_o;
    assign release_en_o = release_en_q;

    always_comb begin
        for (int s = 0; s < NumSlots; s++) begin
            slot_expired[s] = slot_valid_q[s] && (slot_cnt_q[s] == '0);
        end
    end

    // Lowest-index free slot, one-hot, only when a handshake happens.
    always_comb begin
        logic found;
        found    = 1'b0;
        alloc_oh = '0;
        for (int s = 0; s < NumSlots; s++) begin
            if (!slot_valid_q[s] && !found) begin
                alloc_oh[s] = accept;
                found       = 1'b1;
            end
        end
    end

    // Countdown saturates at zero: a zero-count slot is expired and clears
    // instead of decrementing.
    always_comb begin
        slot_valid_d = slot_valid_q;
        for (int s = 0; s < NumSlots; s++) begin
            slot_id_d[s]  = slot_id_q[s];
            slot_cnt_d[s] = slot_cnt_q[s];
            if (slot_expired[s]) begin
                slot_valid_d[s] = 1'b0;
            end else if (slot_valid_q[s]) begin
                slot_cnt_d[s] = slot_cnt_q[s] - DelayWidth'(1);
            end
            if (alloc_oh[s]) begin
                slot_valid_d[s] = 1'b1;
                slot_id_d[s]    = req_id_i;
                slot_cnt_d[s]   = req_delay_i;
            end
        end
    end

    // Every expiring slot adds one credit to its ID, so same-ID expiries in
    // one cycle accumulate. A done only decrements a nonzero registered
    // credit; the net of expiry and done is applied in a single edge.
    always_comb begin
        credit_overflow  = 1'b0;
        credit_underflow = 1'b0;
        for (int i = 0; i < NumIds; i++) begin
            credit_d[i] = credit_q[i];
        end
        for (int s = 0; s < NumSlots; s++) begin
            if (slot_expired[s]) begin
                if (credit_d[slot_id_q[s]] == '1) begin
                    credit_overflow = 1'b1;
                end
                credit_d[slot_id_q[s]] = credit_d[slot_id_q[s]] + CreditWidth'(1);
            end
        end
        if (rel_done_i) begin
            if (credit_q[rel_done_id_i] == '0) begin
                credit_underflow = 1'b1;
            end else begin
                credit_d[rel_done_id_i] = credit_d[rel_done_id_i] - CreditWidth'(1);
            end
        end
        for (int i = 0; i < NumIds; i++) begin
            release_en_d[i] = (credit_d[i] != '0);
        end
    end

    // The enable is registered from the next credit value, so it always equals
    // (credit_q != 0) and is forced low the moment reset asserts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_valid_q <= '0;
            for (int s = 0; s < NumSlots; s++) begin
                slot_id_q[s]  <= '0;
                slot_cnt_q[s] <= '0;
            end
            for (int i = 0; i < NumIds; i++) begin
                credit_q[i] <= '0;
            end
            release_en_q <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            for (int s = 0; s < NumSlots; s++) begin
                slot_id_q[s]  <= slot_id_d[s];
                slot_cnt_q[s] <= slot_cnt_d[s];
            end
            for (int i = 0; i < NumIds; i++) begin
                credit_q[i] <= credit_d[i];
            end
            release_en_q <= release_en_d;
        end
    end

`ifndef SYNTHESIS
    a_alloc_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        accept |-> $onehot(alloc_oh));
    a_no_alloc_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (&slot_valid_q) |-> (alloc_oh == '0));
    a_no_credit_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !credit_overflow);
    a_no_credit_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !credit_underflow);
    a_ready_when_free: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (|(~slot_valid_q)) |-> req_ready_o);
`endif

endmodule
